// File: rtl/wb_conbus_pkg.sv
// Shared types and helpers for the round-robin Wishbone conbus.
package wb_conbus_pkg;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int SEL_W = DEF_DATA_W / 8;

    localparam logic [23:0] DEF_MAP = {
        3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v)
                r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus arbiter; grant is held until the owner drops its request.
module wb_rr_arbiter
    import wb_conbus_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [GW-1:0] gnt,
    output logic          gnt_valid
);

    arb_state_t    state;
    logic [GW-1:0] last;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;

    // scan downward so the closest requester after last wins
    always_comb begin
        pick = last;
        idx  = '0;
        for (int i = N; i >= 1; i--) begin
            idx = GW'((int'(last) + i) % N);
            if (req[idx])
                pick = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last      <= GW'(N - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= pick;
                        last      <= pick;
                        gnt_valid <= 1'b1;
                        state     <= OWNED;
                    end
                end
                OWNED: begin
                    if (!req[gnt]) begin
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_conbus_rr.sv
// N-master/M-slave Wishbone shared bus with round-robin arbitration.
// Define WB_CONBUS_TIMEOUT_EN to add the stalled-slave timeout error.
module wb_conbus_rr
    import wb_conbus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 8,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int S_ADDR_W  = 3,
    parameter logic [N_SLAVES*S_ADDR_W-1:0] S_ADDR_MAP = DEF_MAP,
    parameter int TIMEOUT   = 255,
    localparam int GW  = (clog2(N_MASTERS) > 1) ? clog2(N_MASTERS) : 1,
    localparam int SW  = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*DATA_W-1:0] m_dat_i,
    input  logic [N_MASTERS*ADDR_W-1:0] m_adr_i,
    input  logic [N_MASTERS*SW-1:0]     m_sel_i,
    input  logic [N_MASTERS-1:0]        m_we_i,
    input  logic [N_MASTERS-1:0]        m_cyc_i,
    input  logic [N_MASTERS-1:0]        m_stb_i,
    output logic [DATA_W-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]        m_ack_o,
    output logic [N_MASTERS-1:0]        m_err_o,
    input  logic [N_SLAVES*DATA_W-1:0]  s_dat_i,
    input  logic [N_SLAVES-1:0]         s_ack_i,
    output logic [DATA_W-1:0]           s_dat_o,
    output logic [ADDR_W-1:0]           s_adr_o,
    output logic [SW-1:0]               s_sel_o,
    output logic                        s_we_o,
    output logic [N_SLAVES-1:0]         s_cyc_o,
    output logic [N_SLAVES-1:0]         s_stb_o,
    output logic [GW-1:0]               gnt_o,
    output logic                        gnt_valid_o
);

    localparam int SIW = (clog2(N_SLAVES) > 1) ? clog2(N_SLAVES) : 1;

    typedef logic [clog2(TIMEOUT + 1)-1:0] to_cnt_t;

    logic [GW-1:0]       gnt;
    logic                gnt_valid;
    logic [S_ADDR_W-1:0] tag;
    logic [SIW-1:0]      hit_idx;
    logic                any_hit;
    logic                cyc_g;
    logic                stb_g;
    logic                bus_on;
    logic                miss;
    logic                to_fire;
    logic                err_q;
    logic [N_SLAVES-1:0] slv_vec;
    logic [N_MASTERS-1:0] mst_vec;

    wb_rr_arbiter #(
        .N  (N_MASTERS),
        .GW (GW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (m_cyc_i),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    assign s_dat_o = m_dat_i[gnt*DATA_W +: DATA_W];
    assign s_adr_o = m_adr_i[gnt*ADDR_W +: ADDR_W];
    assign s_sel_o = m_sel_i[gnt*SW +: SW];
    assign s_we_o  = m_we_i[gnt];
    assign cyc_g   = m_cyc_i[gnt];
    assign stb_g   = m_stb_i[gnt];
    assign tag     = s_adr_o[ADDR_W-1 -: S_ADDR_W];

    // descending scan lets the lowest matching slave win
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (tag == S_ADDR_MAP[k*S_ADDR_W +: S_ADDR_W]) begin
                any_hit = 1'b1;
                hit_idx = SIW'(k);
            end
        end
    end

    assign bus_on  = gnt_valid & cyc_g;
    assign miss    = bus_on & stb_g & ~any_hit;
    assign slv_vec = N_SLAVES'(1) << hit_idx;
    assign mst_vec = N_MASTERS'(1) << gnt;

    assign s_cyc_o = (bus_on & any_hit) ? slv_vec : '0;
    assign s_stb_o = (bus_on & stb_g & any_hit & ~to_fire)
                   ? slv_vec : '0;

    assign m_ack_o = (gnt_valid & any_hit & s_ack_i[hit_idx])
                   ? mst_vec : '0;
    assign m_dat_o = any_hit ? s_dat_i[hit_idx*DATA_W +: DATA_W]
                             : '0;
    assign m_err_o = (err_q | to_fire) ? mst_vec : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else
            err_q <= miss & ~err_q;
    end

`ifdef WB_CONBUS_TIMEOUT_EN
    to_cnt_t to_cnt;
    logic    stall;

    assign stall   = bus_on & stb_g & any_hit & ~s_ack_i[hit_idx];
    assign to_fire = gnt_valid & (to_cnt == to_cnt_t'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (to_fire || !stall)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_fire = 1'b0;
`endif

    assign gnt_o       = gnt;
    assign gnt_valid_o = gnt_valid;

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Scoreboard bench for wb_conbus_rr: 2 masters, 4 slaves, TIMEOUT=16.
module tb_wb_conbus_rr;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM-1:0]    m_we_i;
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [NS*DW-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i;
    logic [DW-1:0]    s_dat_o;
    logic [AW-1:0]    s_adr_o;
    logic [SW-1:0]    s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o;
    logic [NS-1:0]    s_stb_o;
    logic             gnt_o;
    logic             gnt_valid_o;

    wb_conbus_rr #(
        .N_MASTERS  (NM),
        .N_SLAVES   (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .S_ADDR_W   (3),
        .S_ADDR_MAP ({3'd3, 3'd2, 3'd1, 3'd0}),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_dat_i     (m_dat_i),
        .m_adr_i     (m_adr_i),
        .m_sel_i     (m_sel_i),
        .m_we_i      (m_we_i),
        .m_cyc_i     (m_cyc_i),
        .m_stb_i     (m_stb_i),
        .m_dat_o     (m_dat_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .s_dat_i     (s_dat_i),
        .s_ack_i     (s_ack_i),
        .s_dat_o     (s_dat_o),
        .s_adr_o     (s_adr_o),
        .s_sel_o     (s_sel_o),
        .s_we_o      (s_we_o),
        .s_cyc_o     (s_cyc_o),
        .s_stb_o     (s_stb_o),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] dat_q[$];
    logic [31:0] gnt_q[$];
    logic [31:0] err_q[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clear_bus();
        m_dat_i = '0;
        m_adr_i = '0;
        m_sel_i = '0;
        m_we_i  = '0;
        m_cyc_i = '0;
        m_stb_i = '0;
        s_dat_i = '0;
        s_ack_i = '0;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb,
                         input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        m_cyc_i[m]         = cyc;
        m_stb_i[m]         = stb;
        m_we_i[m]          = we;
        m_adr_i[m*AW +: AW] = adr;
        m_dat_i[m*DW +: DW] = dat;
        m_sel_i[m*SW +: SW] = sel;
    endtask

    task automatic do_reset();
        samp();
        rst = 1'b0;
        clear_bus();
        #12;
        samp();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int first_err;

    initial begin
        // reset state
        clear_bus();
        m_adr_i[31:0]  = 32'h1234_5678;
        m_adr_i[63:32] = 32'h8765_4321;
        #12;
        check("rst_gnt_valid", 32'(gnt_valid_o), 32'd0);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_m_err", 32'(m_err_o), 32'd0);
        check("rst_bcast_adr", s_adr_o, 32'h1234_5678);
        samp();
        rst = 1'b1;
        clear_bus();

        // single read, slave 1 acks on third cycle
        next();
        set_m(0, 1, 1, 0, 32'h2000_0004, 32'h0, 4'hF);
        dat_q.push_back(32'hDEAD_BEEF);
        samp();
        check("rd_gnt_latency", 32'(gnt_valid_o), 32'd0);
        check("rd_no_cyc_yet", 32'(s_cyc_o), 32'd0);
        next();
        samp();
        check("rd_gnt_valid", 32'(gnt_valid_o), 32'd1);
        check("rd_gnt", 32'(gnt_o), 32'd0);
        check("rd_s_cyc", 32'(s_cyc_o), 32'b0010);
        check("rd_s_stb", 32'(s_stb_o), 32'b0010);
        check("rd_no_ack1", 32'(m_ack_o), 32'd0);
        next();
        samp();
        check("rd_no_ack2", 32'(m_ack_o), 32'd0);
        next();
        s_ack_i[1]          = 1'b1;
        s_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
        samp();
        check("rd_ack", 32'(m_ack_o), 32'b01);
        check("rd_data", m_dat_o, dat_q.pop_front());
        next();
        clear_bus();
        samp();
        next();
        samp();

        // simultaneous requests after reset: 0,1,0,1
        do_reset();
        next();
        set_m(0, 1, 0, 0, 32'h0000_0000, 32'h0, 4'h0);
        set_m(1, 1, 0, 0, 32'h2000_0000, 32'h0, 4'h0);
        gnt_q.push_back(32'd0);
        gnt_q.push_back(32'd1);
        gnt_q.push_back(32'd0);
        gnt_q.push_back(32'd1);
        samp();
        next();
        samp();
        check("arb_valid_a", 32'(gnt_valid_o), 32'd1);
        check("arb_gnt_a", 32'(gnt_o), gnt_q.pop_front());
        next();
        m_cyc_i[0] = 1'b0;
        samp();
        next();
        samp();
        check("arb_idle_gap", 32'(gnt_valid_o), 32'd0);
        next();
        samp();
        check("arb_gnt_b", 32'(gnt_o), gnt_q.pop_front());
        check("arb_valid_b", 32'(gnt_valid_o), 32'd1);
        next();
        m_cyc_i = 2'b00;
        samp();
        next();
        m_cyc_i = 2'b11;
        samp();
        next();
        samp();
        check("arb_gnt_c", 32'(gnt_o), gnt_q.pop_front());
        next();
        m_cyc_i[0] = 1'b0;
        samp();
        next();
        samp();
        next();
        samp();
        check("arb_gnt_d", 32'(gnt_o), gnt_q.pop_front());
        next();
        clear_bus();
        samp();
        next();
        samp();

        // decode miss
        next();
        set_m(0, 1, 1, 0, 32'hE000_0000, 32'h0, 4'hF);
        err_q.push_back(32'b00);
        err_q.push_back(32'b01);
        err_q.push_back(32'b00);
        samp();
        next();
        samp();
        check("miss_gnt", 32'(gnt_valid_o), 32'd1);
        check("miss_no_cyc", 32'(s_cyc_o), 32'd0);
        check("miss_err_0", 32'(m_err_o), err_q.pop_front());
        next();
        samp();
        check("miss_err_1", 32'(m_err_o), err_q.pop_front());
        check("miss_no_ack", 32'(m_ack_o), 32'd0);
        next();
        m_stb_i[0] = 1'b0;
        samp();
        check("miss_err_2", 32'(m_err_o), err_q.pop_front());
        next();
        clear_bus();
        samp();
        next();
        samp();

        // stalled slave 3
        next();
        set_m(0, 1, 1, 0, 32'h6000_0000, 32'h0, 4'hF);
        samp();
        first_err = -1;
        for (int k = 0; k <= 40; k++) begin
            next();
            samp();
            if (m_err_o != 2'b00) begin
                first_err = k;
`ifdef WB_CONBUS_TIMEOUT_EN
                check("to_stb_low", 32'(s_stb_o), 32'd0);
`endif
                break;
            end
        end
`ifdef WB_CONBUS_TIMEOUT_EN
        check("to_err_cycle", 32'(first_err), 32'd16);
`else
        check("to_never_err", 32'(first_err), 32'hFFFF_FFFF);
`endif
        next();
        clear_bus();
        samp();
        next();
        samp();

        // write by master 1, reset mid-transaction
        next();
        set_m(1, 1, 1, 1, 32'h4000_0010, 32'hCAFE_F00D, 4'b0010);
        s_ack_i[2] = 1'b1;
        samp();
        next();
        samp();
        check("wr_gnt", 32'(gnt_o), 32'd1);
        check("wr_s_cyc", 32'(s_cyc_o), 32'b0100);
        check("wr_sel", 32'(s_sel_o), 32'b0010);
        check("wr_we", 32'(s_we_o), 32'd1);
        check("wr_dat", s_dat_o, 32'hCAFE_F00D);
        check("wr_ack", 32'(m_ack_o), 32'b10);
        #2;
        rst = 1'b0;
        #1;
        check("arst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("arst_s_stb", 32'(s_stb_o), 32'd0);
        check("arst_m_ack", 32'(m_ack_o), 32'd0);
        check("arst_gnt_valid", 32'(gnt_valid_o), 32'd0);
        clear_bus();
        next();
        rst = 1'b1;
        next();
        next();
        next();
        samp();
        check("post_rst_idle", 32'(gnt_valid_o), 32'd0);

        check("sb_empty", 32'(dat_q.size() + gnt_q.size() + err_q.size()),
              32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_conbus_rr.md
Name: wb_conbus_rr

Overview:
Parametrised Wishbone shared-bus interconnect. Next generation of the fixed 2-master/4-slave conbus.
- N masters (LM32 I/D plus future DMA) and M slaves, each with a configurable top-address-bit match.
- Round-robin arbitration held for the whole cycle.
- Decode-miss error response, plus optional stalled-slave timeout.
- Sits between lm32_cpu and bram/uart/timer/i2c/pantalla/pH peripherals in system.

Parameters:
N_MASTERS, 2, number of masters (1..8)
N_SLAVES, 8, number of slaves (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
S_ADDR_W, 3, number of top address bits decoded
S_ADDR_MAP, {7,6,5,4,3,2,1,0} packed N_SLAVES*S_ADDR_W, match value per slave; slave i uses bits [i*S_ADDR_W +: S_ADDR_W]
TIMEOUT, 255, stall cycles before error (used only with WB_CONBUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
m_dat_i  in  N_MASTERS*DATA_W  master write data
m_adr_i  in  N_MASTERS*ADDR_W  master address
m_sel_i  in  N_MASTERS*DATA_W/8  byte selects
m_we_i  in  N_MASTERS  write enable
m_cyc_i  in  N_MASTERS  cycle
m_stb_i  in  N_MASTERS  strobe
m_dat_o  out  DATA_W  read data, broadcast to all masters
m_ack_o  out  N_MASTERS  acknowledge
m_err_o  out  N_MASTERS  error
s_dat_i  in  N_SLAVES*DATA_W  slave read data
s_ack_i  in  N_SLAVES  slave acknowledge
s_dat_o  out  DATA_W  write data, broadcast
s_adr_o  out  ADDR_W  address, broadcast
s_sel_o  out  DATA_W/8  byte selects, broadcast
s_we_o  out  1  write enable, broadcast
s_cyc_o  out  N_SLAVES  per-slave cycle
s_stb_o  out  N_SLAVES  per-slave strobe
gnt_o  out  max(1,$clog2(N_MASTERS))  current owner index (debug)
gnt_valid_o  out  1  bus owned

Behaviour:
- Interface: one clock (clk); reset asynchronous and active-low (rst).
- Reset (rst=0): gnt=0, gnt_valid=0, last=N_MASTERS-1, error pulse cleared, timeout counter 0. All s_cyc_o, s_stb_o, m_ack_o and m_err_o are 0 immediately, including mid-transaction. Broadcast outputs follow master 0.
- Arbiter FSM:
  - IDLE: on a clk edge with any m_cyc_i high, pick the first requester scanning last+1, last+2, … modulo N_MASTERS. Set gnt to it, set last=gnt, go to OWNED.
  - OWNED: hold while m_cyc_i[gnt]=1. On an edge where m_cyc_i[gnt]=0, return to IDLE with gnt_valid=0. Re-arbitration happens on the following edge.
  - No preemption.
  - Latency: one cycle grant latency from an idle bus; zero added latency on data/ack paths once granted.
- Decode: compare the granted master's adr[ADDR_W-1 -: S_ADDR_W] with each map entry. On multiple matches the lowest index wins.
  - s_cyc_o[k] = gnt_valid & m_cyc_i[gnt] & hit[k].
  - s_stb_o[k] = the same with m_stb_i[gnt].
  - Broadcast outputs are muxed from gnt.
- Return path (all others 0):
  - m_ack_o[gnt] = s_ack_i[hit index] & gnt_valid.
  - m_dat_o = s_dat_i[hit index]; 0 on miss.
- Decode miss: when stb is high with no hit, m_err_o[gnt] is a registered one-cycle pulse on the cycle after stb is seen. It does not re-fire until stb drops or a further cycle passes (err_q <= miss & stb & ~err_q). No slave sees cyc.
- Simultaneous requests at reset: master 0 wins (last=N_MASTERS-1). Next contention: master 1.

Optional Feature:
WB_CONBUS_TIMEOUT_EN.
- With it: a counter increments each cycle a hit slave has stb high and ack low. It clears on ack or when stb is low. At count==TIMEOUT, m_err_o[gnt] pulses one cycle, the counter clears, and s_stb_o is forced low that cycle. The owner keeps the grant until it drops cyc.
- Without it: no counter, no TIMEOUT logic; a stalled slave hangs the bus.

Decomposition:
- Package wb_conbus_pkg: arbiter state enum (IDLE, OWNED), function clog2, localparam SEL_W=DATA_W/8, default map constant.
- Sub-module wb_rr_arbiter: request vector in, gnt/gnt_valid out, holds last-grant pointer.
- Decode, muxing and error/timeout logic stay in the top.

Test Plan:
- Single master 0 reads 0x20000004, slave1 acks after 2 cycles with 0xDEADBEEF:
  - only s_cyc_o[1] high;
  - m_ack_o=2'b01 and m_dat_o=0xDEADBEEF on the ack cycle;
  - grant one cycle after cyc.
- Both masters raise cyc on the same cycle after reset:
  - master 0 granted;
  - master 1 granted on the cycle after master 0 drops cyc;
  - repeat contention: master 0 granted again (alternation).
- Map with N_SLAVES=4 (0..3); access 0xE0000000:
  - no s_cyc_o;
  - m_err_o pulses exactly 1 cycle, one cycle after stb;
  - m_ack_o stays 0.
- With WB_CONBUS_TIMEOUT_EN, TIMEOUT=16, slave never acks:
  - err pulse exactly 16 cycles after stb;
  - without the macro, no err ever.
- rst driven low while master 1 owns the bus mid-write:
  - all s_cyc_o/stb and m_ack_o drop asynchronously;
  - after release, gnt_valid=0 until a new request.
- Write with m_sel_i=4'b0010 to slave 2: s_sel_o=4'b0010, s_we_o=1, s_dat_o equals the master data.
